// File: rtl/uart_msg_streamer_if.sv
// AXI-Stream byte channel between the message streamer and uart_tx.
// The master drives tdata/tvalid and the slave answers with tready.
interface uart_msg_streamer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_msg_streamer.sv
// Streams a fixed MSG_LEN-byte message (FIRST_CHAR, FIRST_CHAR+1, ...) into
// uart_tx over an AXI-Stream master port. After each accepted byte, tvalid
// stays low for GAP_CYCLES extra cycles. Status outputs drive the board LEDs.
module uart_msg_streamer #(
    parameter  int CLK_FREQ   = 25_000_000,
    parameter  int MSG_LEN    = 26,
    parameter  int FIRST_CHAR = 65,
    parameter  int GAP_CYCLES = 8,
    localparam int IW         = $clog2(MSG_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    uart_msg_streamer_if.master m_axis,
    output logic [IW-1:0]       byte_idx,
    output logic                busy,
    output logic                done,
    output logic                complete
);

    // Gap counter needs at least one bit even when GAP_CYCLES is zero.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(MSG_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    if (MSG_LEN < 1) begin : g_bad_len
        $error("uart_msg_streamer: MSG_LEN must be at least 1");
    end
    if (GAP_CYCLES < 0 || CLK_FREQ < 1) begin : g_bad_timing
        $error("uart_msg_streamer: GAP_CYCLES must be >= 0 and CLK_FREQ >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    logic [GW-1:0]   gap_cnt;

    // NOTE: the message is computed from its index rather than stored, so
    // there is no byte array that would need (or resist) a reset.
    function automatic logic [7:0] msg_byte(input logic [IW-1:0] idx);
        return 8'(FIRST_CHAR + 32'(idx));
    endfunction

    // Single registered FSM: every output is a flop updated on the clock edge.
    // NOTE: non-blocking (<=) assignments throughout, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= 8'h00;
            byte_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            complete      <= 1'b0;
            gap_cnt       <= '0;
        end else if (abort) begin
            // Abort beats start and any same-cycle transfer; that byte is
            // already owned by uart_tx and is not replayed.
            state         <= S_IDLE;
            m_axis.tvalid <= 1'b0;
            byte_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            complete      <= 1'b0;
            gap_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_SEND;
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= msg_byte('0);
                        byte_idx      <= '0;
                        busy          <= 1'b1;
                        complete      <= 1'b0;
                    end
                end
                S_SEND: begin
                    // Without a transfer everything holds: tvalid and tdata
                    // must stay put until uart_tx takes the byte.
                    if (m_axis.tvalid && m_axis.tready) begin
                        m_axis.tvalid <= 1'b0;
                        if (byte_idx == LAST_IDX) begin
                            state    <= S_DONE;
                            byte_idx <= END_IDX;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            complete <= 1'b1;
                        end else begin
                            state    <= S_GAP;
                            byte_idx <= byte_idx + IW'(1);
                            gap_cnt  <= '0;
                        end
                    end
                end
                S_GAP: begin
                    // One mandatory idle cycle plus GAP_CYCLES extra ones.
                    if (gap_cnt == GAP_LAST) begin
                        state         <= S_SEND;
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= msg_byte(byte_idx);
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Self-checking bench for uart_msg_streamer. Two instances with different
// parameters share the stimulus; a negedge monitor scores the selected one
// against a message-level model (expected byte sequence, gap timing, done).
module tb_uart_msg_streamer;

    localparam int A_LEN   = 26;
    localparam int A_FIRST = 65;
    localparam int A_GAP   = 8;
    localparam int B_LEN   = 8;
    localparam int B_FIRST = 250;
    localparam int B_GAP   = 0;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic tready = 1'b0;
    logic sel    = 1'b0;

    uart_msg_streamer_if a_if ();
    uart_msg_streamer_if b_if ();
    assign a_if.tready = tready;
    assign b_if.tready = tready;

    logic [4:0] a_idx;
    logic [3:0] b_idx;
    logic       a_busy, a_done, a_complete;
    logic       b_busy, b_done, b_complete;

    uart_msg_streamer #(
        .MSG_LEN(A_LEN), .FIRST_CHAR(A_FIRST), .GAP_CYCLES(A_GAP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .m_axis(a_if), .byte_idx(a_idx), .busy(a_busy), .done(a_done),
        .complete(a_complete)
    );

    uart_msg_streamer #(
        .MSG_LEN(B_LEN), .FIRST_CHAR(B_FIRST), .GAP_CYCLES(B_GAP)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .m_axis(b_if), .byte_idx(b_idx), .busy(b_busy), .done(b_done),
        .complete(b_complete)
    );

    // Outputs and parameters of the instance under observation.
    logic        c_valid, c_busy, c_done, c_complete;
    logic [7:0]  c_data;
    logic [31:0] c_idx;
    int          c_len, c_first, c_gap;
    assign c_valid    = sel ? b_if.tvalid : a_if.tvalid;
    assign c_data     = sel ? b_if.tdata  : a_if.tdata;
    assign c_idx      = sel ? 32'(b_idx)  : 32'(a_idx);
    assign c_busy     = sel ? b_busy      : a_busy;
    assign c_done     = sel ? b_done      : a_done;
    assign c_complete = sel ? b_complete  : a_complete;
    assign c_len      = sel ? B_LEN   : A_LEN;
    assign c_first    = sel ? B_FIRST : A_FIRST;
    assign c_gap      = sel ? B_GAP   : A_GAP;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always #5 clk = ~clk;

    // Model state, owned by the monitor.
    int   cyc, exp_pos, xfer_cnt, done_cnt, pend_cyc, last_cyc;
    bit   pend, prev_valid, prev_ready, prev_abort, prev_done;
    logic [7:0] prev_data;

    // Monitor: samples mid-cycle and scores the selected instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; exp_pos = 0; xfer_cnt = 0; done_cnt = 0;
            pend_cyc = 0; last_cyc = 0; pend = 0;
            prev_valid = 0; prev_ready = 0; prev_abort = 0; prev_done = 0;
            prev_data = 8'h00;
        end else begin
            cyc++;
            if (prev_abort) begin
                check("abort_valid", c_valid, 0);
                check("abort_idx", c_idx, 0);
                check("abort_complete", c_complete, 0);
                check("abort_busy", c_busy, 0);
            end else if (prev_valid && !prev_ready) begin
                check("hold_valid", c_valid, 1);
                check("hold_data", c_data, prev_data);
            end
            if (prev_done) check("done_width", c_done, 0);
            if (c_done) begin
                check("done_pos", exp_pos, c_len);
                check("done_latency", cyc - last_cyc, 1);
                check("done_complete", c_complete, 1);
                check("done_idx", c_idx, c_len);
                check("done_busy", c_busy, 0);
                done_cnt++;
                exp_pos = 0;
            end
            if (pend && !c_valid) check("gap_busy", c_busy, 1);
            if (c_valid && pend) begin
                check("gap_len", cyc - pend_cyc, c_gap + 2);
                pend = 0;
            end else if (c_valid && !prev_valid) begin
                check("start_pos", exp_pos, 0);
                check("start_idx", c_idx, 0);
                check("start_complete", c_complete, 0);
                check("start_busy", c_busy, 1);
            end
            if (c_valid && tready) begin
                check("xfer_data", c_data, (c_first + exp_pos) % 256);
                check("xfer_idx", c_idx, exp_pos);
                xfer_cnt++;
                if (abort) begin
                    exp_pos = 0;
                    pend = 0;
                end else if (exp_pos == c_len - 1) begin
                    exp_pos = c_len;
                    last_cyc = cyc;
                end else begin
                    exp_pos++;
                    pend = 1;
                    pend_cyc = cyc;
                end
            end else if (abort) begin
                exp_pos = 0;
                pend = 0;
            end
            prev_valid = c_valid;
            prev_ready = tready;
            prev_abort = abort;
            prev_done  = c_done;
            prev_data  = c_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", c_valid, 0);
        check("rst_data", c_data, 0);
        check("rst_idx", c_idx, 0);
        check("rst_busy", c_busy, 0);
        check("rst_done", c_done, 0);
        check("rst_complete", c_complete, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rand_ready);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            if (rand_ready) tready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check("done_wait", done_cnt, target);
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("xfer_wait", xfer_cnt, target);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!c_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_wait", c_valid, 1);
    endtask

    int base;

    initial begin
        #2;
        // Full message with tready tied high.
        sel = 1'b0;
        do_reset();
        tready = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(1, 400, 1'b0);
        tick();
        check("t1_xfers", xfer_cnt, A_LEN);
        check("t1_complete", c_complete, 1);
        check("t1_idx", c_idx, A_LEN);
        check("t1_busy", c_busy, 0);
        repeat (5) tick();
        check("t1_done_once", done_cnt, 1);
        check("t1_sticky", c_complete, 1);

        // Long back-pressure mid-message, then random tready to the end.
        base  = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_xfer(base + 10, 200);
        tready = 1'b0;
        repeat (50) tick();
        check("t2_stall_valid", c_valid, 1);
        check("t2_stall_data", c_data, (A_FIRST + 10) % 256);
        check("t2_stall_idx", c_idx, 10);
        wait_done(2, 2000, 1'b1);
        check("t2_xfers", xfer_cnt - base, A_LEN);

        // Abort while byte 5 is offered and stalled.
        tready = 1'b1;
        base   = xfer_cnt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_xfer(base + 5, 200);
        tready = 1'b0;
        wait_valid(30);
        check("t3_idx5", c_idx, 5);
        check("t3_data5", c_data, (A_FIRST + 5) % 256);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_valid", c_valid, 0);
        check("t3_abort_idx", c_idx, 0);
        check("t3_abort_complete", c_complete, 0);
        repeat (3) tick();
        tready = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t3_restart_data", c_data, A_FIRST);
        wait_done(3, 400, 1'b0);

        // Asynchronous reset between clock edges while a byte is offered.
        tick();
        tready = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t5_pre_valid", c_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", c_valid, 0);
        check("t5_async_data", c_data, 0);
        check("t5_async_idx", c_idx, 0);
        check("t5_async_busy", c_busy, 0);
        tick();
        tick();
        rst_n  = 1'b1;
        tready = 1'b1;
        repeat (20) tick();
        check("t5_idle_valid", c_valid, 0);
        check("t5_idle_busy", c_busy, 0);
        check("t5_idle_xfers", xfer_cnt, 0);

        // Wrapping message, zero gap, start held for continuous repeat.
        sel = 1'b1;
        do_reset();
        tready = 1'b1;
        start  = 1'b1;
        wait_done(3, 200, 1'b0);
        check("t4_xfers", xfer_cnt, 3 * B_LEN);
        wait_done(6, 2000, 1'b1);
        start  = 1'b0;
        tready = 1'b1;
        repeat (40) tick();
        check("t4_done_total", done_cnt, 6);
        check("t4_idle_valid", c_valid, 0);
        check("t4_idle_idx", c_idx, B_LEN);
        check("t4_idle_complete", c_complete, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
